// File: rtl/multicycle_control_fsm_if.sv
// Memory handshake bundle between the multicycle control unit and the
// memory/bus side of the datapath.
//   master (control unit): drives MemRequest, MemWrite, InstructionOrData,
//                          MemSize, MemUnsigned; samples MemReady
//   slave  (memory side) : the reverse directions
interface multicycle_control_fsm_if;
  logic       MemRequest;
  logic       MemReady;
  logic       MemWrite;
  logic       InstructionOrData;
  logic [1:0] MemSize;
  logic       MemUnsigned;

  modport master (
    output MemRequest, MemWrite, InstructionOrData, MemSize, MemUnsigned,
    input  MemReady
  );

  modport slave (
    input  MemRequest, MemWrite, InstructionOrData, MemSize, MemUnsigned,
    output MemReady
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Control unit for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, drives every datapath enable and mux select,
// handles a variable-latency memory handshake with optional timeout, and keeps
// cycle / retired-instruction counters.
//
// Parameters: MEM_TIMEOUT (max wait cycles per access, 0 = no timeout),
//             CNT_W (performance counter width).
// Ports: clk, reset (sync, active-high); opcode/funct3/funct7, Zero from the
//        datapath; mem (master modport: MemRequest/MemReady/MemWrite/
//        InstructionOrData/MemSize/MemUnsigned); datapath enables PCEnable,
//        InstructionRegisterEnable, REGAEnable, REGBEnable, RegWrite;
//        selects ImmediateSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControlSignal;
//        sticky Illegal/BusError; CycleCount, InstRetired.
// Mux encodings: ALUSrcA 00 PC, 01 OldPC, 10 rs1 reg;
//                ALUSrcB 00 rs2 reg, 01 ImmExt, 10 const 4;
//                ResultSrc 00 ALUOut, 01 memory data, 10 ALUResult, 11 ImmExt.
// Build option: define ILLEGAL_TRAP_EN to trap on illegal encodings.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [6:0]                 opcode,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic                       Zero,
  multicycle_control_fsm_if.master   mem,
  output logic                       PCEnable,
  output logic                       InstructionRegisterEnable,
  output logic                       REGAEnable,
  output logic                       REGBEnable,
  output logic                       RegWrite,
  output logic [2:0]                 ImmediateSrc,
  output logic [1:0]                 ALUSrcA,
  output logic [1:0]                 ALUSrcB,
  output logic [1:0]                 ResultSrc,
  output logic [3:0]                 ALUControlSignal,
  output logic                       Illegal,
  output logic                       BusError,
  output logic [CNT_W-1:0]           CycleCount,
  output logic [CNT_W-1:0]           InstRetired
);

  typedef enum logic [3:0] {
    FETCH, DECODE, RTYPE_EXEC, IMM_EXEC, ALU_WB, JAL_EXEC, JALR_EXEC, JALR_LINK,
    BRANCH, MEM_ADDR, LOAD_ACCESS, LOAD_WB, STORE_ACCESS, LUI_WB, AUIPC_EXEC, TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  localparam int unsigned      WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t             r_state, w_next, w_dec;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_cycle, r_inst;
  logic               r_bus_err;
  logic               w_illegal_enc, w_timeout, w_taken, w_alt, w_in_mem, w_retire;
  logic               w_mem_req, w_mem_write, w_iord, w_uns;
  logic [1:0]         w_size;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0101;
      3'b010:  alu_op = 4'b1101;
      3'b011:  alu_op = 4'b1000;
      3'b100:  alu_op = 4'b0100;
      3'b101:  alu_op = alt ? 4'b0111 : 4'b0110;
      3'b110:  alu_op = 4'b0011;
      default: alu_op = 4'b0010;
    endcase
  endfunction

  // sub/sra variant selected by the canonical funct7 pattern
  assign w_alt     = (funct7 == 7'b0100000);
  assign w_in_mem  = (r_state == FETCH) || (r_state == LOAD_ACCESS) || (r_state == STORE_ACCESS);
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_MAX) && !mem.MemReady;
  // Output decode follows FETCH while reset is held, whatever r_state is.
  assign w_dec     = reset ? FETCH : r_state;
  assign w_retire  = (w_next == FETCH) && (r_state != FETCH);

  always_comb begin
    w_illegal_enc = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: w_illegal_enc = 1'b0;
      OP_LOAD:  w_illegal_enc = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OP_STORE: w_illegal_enc = (funct3 >= 3'b011);
      OP_BR:    w_illegal_enc = (funct3[2:1] == 2'b01);
      default:  w_illegal_enc = 1'b1;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000, 3'b101, 3'b111: w_taken = Zero;
      3'b001, 3'b100, 3'b110: w_taken = !Zero;
      default:                w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next                    = r_state;
    PCEnable                  = 1'b0;
    InstructionRegisterEnable = 1'b0;
    REGAEnable                = 1'b0;
    REGBEnable                = 1'b0;
    RegWrite                  = 1'b0;
    ImmediateSrc              = 3'b000;
    ALUSrcA                   = 2'b00;
    ALUSrcB                   = 2'b00;
    ResultSrc                 = 2'b00;
    ALUControlSignal          = 4'b0000;
    w_mem_req                 = 1'b0;
    w_mem_write               = 1'b0;
    w_iord                    = 1'b0;
    w_size                    = 2'b10;
    w_uns                     = 1'b0;

    case (r_state)
      FETCH:        if (mem.MemReady) w_next = DECODE; else if (w_timeout) w_next = TRAP;
      DECODE: begin
        if (w_illegal_enc) begin
`ifdef ILLEGAL_TRAP_EN
          w_next = TRAP;
`else
          w_next = FETCH;
`endif
        end else begin
          case (opcode)
            OP_R:              w_next = RTYPE_EXEC;
            OP_I:              w_next = IMM_EXEC;
            OP_LOAD, OP_STORE: w_next = MEM_ADDR;
            OP_BR:             w_next = BRANCH;
            OP_JAL:            w_next = JAL_EXEC;
            OP_JALR:           w_next = JALR_EXEC;
            OP_LUI:            w_next = LUI_WB;
            OP_AUIPC:          w_next = AUIPC_EXEC;
            default:           w_next = FETCH;
          endcase
        end
      end
      RTYPE_EXEC, IMM_EXEC, AUIPC_EXEC, JAL_EXEC, JALR_LINK: w_next = ALU_WB;
      JALR_EXEC:    w_next = JALR_LINK;
      ALU_WB, LOAD_WB, LUI_WB, BRANCH: w_next = FETCH;
      MEM_ADDR:     w_next = (opcode == OP_STORE) ? STORE_ACCESS : LOAD_ACCESS;
      LOAD_ACCESS:  if (mem.MemReady) w_next = LOAD_WB; else if (w_timeout) w_next = TRAP;
      STORE_ACCESS: if (mem.MemReady) w_next = FETCH;   else if (w_timeout) w_next = TRAP;
      default:      w_next = TRAP;
    endcase

    case (w_dec)
      FETCH: begin
        w_mem_req                 = 1'b1;
        PCEnable                  = mem.MemReady && !reset;
        InstructionRegisterEnable = mem.MemReady;
        ALUSrcB                   = 2'b10;
        ResultSrc                 = 2'b10;
      end
      DECODE: begin
        REGAEnable   = 1'b1;
        REGBEnable   = 1'b1;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b01;
        ImmediateSrc = (opcode == OP_BR) ? 3'b010 : 3'b100;
      end
      RTYPE_EXEC: begin
        ALUSrcA          = 2'b10;
        ALUControlSignal = alu_op(funct3, w_alt);
      end
      IMM_EXEC: begin
        ALUSrcA          = 2'b10;
        ALUSrcB          = 2'b01;
        ALUControlSignal = alu_op(funct3, w_alt && (funct3 == 3'b101));
      end
      ALU_WB:  RegWrite = 1'b1;
      JAL_EXEC: begin
        // PC takes the target precomputed in DECODE; ALU forms the link value
        PCEnable = 1'b1;
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
      end
      JALR_EXEC: begin
        PCEnable  = 1'b1;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
      end
      JALR_LINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      BRANCH: begin
        PCEnable         = w_taken;
        ALUSrcA          = 2'b10;
        ImmediateSrc     = 3'b010;
        ALUControlSignal = (funct3[2:1] == 2'b00) ? 4'b0001 :
                           (funct3[1] ? 4'b1000 : 4'b1101);
      end
      MEM_ADDR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ImmediateSrc = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      LOAD_ACCESS: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_size    = funct3[1:0];
        w_uns     = funct3[2];
      end
      LOAD_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        w_size    = funct3[1:0];
        w_uns     = funct3[2];
      end
      STORE_ACCESS: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        w_size      = funct3[1:0];
      end
      LUI_WB: begin
        RegWrite     = 1'b1;
        ImmediateSrc = 3'b011;
        ResultSrc    = 2'b11;
      end
      AUIPC_EXEC: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b01;
        ImmediateSrc = 3'b011;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_wait    <= '0;
      r_cycle   <= '0;
      r_inst    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counts only while parked in the same memory state; any entry clears it.
      if (w_in_mem && (w_next == r_state) && (MEM_TIMEOUT != 0))
        r_wait <= r_wait + WAIT_W'(1);
      else
        r_wait <= '0;
      if (r_state != TRAP) r_cycle <= r_cycle + CNT_W'(1);
      if (w_retire)        r_inst  <= r_inst + CNT_W'(1);
      if (w_in_mem && (w_next == TRAP)) r_bus_err <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (reset)                                     r_illegal <= 1'b0;
    else if ((r_state == DECODE) && (w_next == TRAP)) r_illegal <= 1'b1;
  end
  assign Illegal = r_illegal;
`else
  assign Illegal = 1'b0;
`endif

  assign BusError              = r_bus_err;
  assign CycleCount            = r_cycle;
  assign InstRetired           = r_inst;
  assign mem.MemRequest        = w_mem_req;
  assign mem.MemWrite          = w_mem_write;
  assign mem.InstructionOrData = w_iord;
  assign mem.MemSize           = w_size;
  assign mem.MemUnsigned       = w_uns;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  localparam int unsigned TO = 4;
  localparam int unsigned CW = 8;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_FEN = 7'b0001111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, Zero, rdy;
  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic          PCEnable, InstructionRegisterEnable, REGAEnable, REGBEnable, RegWrite;
  logic [2:0]    ImmediateSrc;
  logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]    ALUControlSignal;
  logic          Illegal, BusError;
  logic [CW-1:0] CycleCount, InstRetired;

  multicycle_control_fsm_if mif();
  assign mif.MemReady = rdy;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem(mif), .PCEnable(PCEnable),
    .InstructionRegisterEnable(InstructionRegisterEnable), .REGAEnable(REGAEnable),
    .REGBEnable(REGBEnable), .RegWrite(RegWrite), .ImmediateSrc(ImmediateSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControlSignal(ALUControlSignal), .Illegal(Illegal), .BusError(BusError),
    .CycleCount(CycleCount), .InstRetired(InstRetired)
  );

  // en = {PCEnable, IREnable, InstructionOrData, REGAEnable, REGBEnable, RegWrite, MemWrite}
  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       rdy;
    logic [6:0] en;
    logic       mreq;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [1:0] sa, sb, rs, sz;
    logic       uns;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic rst, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic z, logic r, logic [6:0] en, logic mreq, logic [3:0] alu,
                              logic [2:0] imm, logic [1:0] sa, logic [1:0] sb, logic [1:0] rs,
                              logic [1:0] sz, logic uns);
    vec_t v;
    v = '{rst, op, f3, f7, z, r, en, mreq, alu, imm, sa, sb, rs, sz, uns};
    return v;
  endfunction

  function automatic vec_t fetch(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic r);
    return mk(1'b0, op, f3, f7, 1'b0, r, {r, r, 5'b0}, 1'b1, 4'h0, 3'd0, 2'd0, 2'd2, 2'd2, 2'd2, 1'b0);
  endfunction

  function automatic vec_t decode(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [2:0] imm);
    return mk(1'b0, op, f3, f7, 1'b0, 1'b1, 7'b0001100, 1'b0, 4'h0, imm, 2'd1, 2'd1, 2'd0, 2'd2, 1'b0);
  endfunction

  function automatic vec_t wb(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    return mk(1'b0, op, f3, f7, 1'b0, 1'b1, 7'b0000010, 1'b0, 4'h0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0);
  endfunction

  function automatic logic [23:0] act_out();
    return {PCEnable, InstructionRegisterEnable, mif.InstructionOrData, REGAEnable, REGBEnable,
            RegWrite, mif.MemWrite, mif.MemRequest, ALUControlSignal, ImmediateSrc,
            ALUSrcA, ALUSrcB, ResultSrc, mif.MemSize, mif.MemUnsigned};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rdy   = 1'b0;
    Zero  = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [23:0] a, e;
    logic [9:0]  ill [4];

    reset = 1'b1; rdy = 1'b0; Zero = 1'b0;
    opcode = OP_R; funct3 = 3'd0; funct7 = 7'd0;
    cyc();

    // reset row: FETCH decode with PCEnable masked
    tbl.push_back(mk(1'b1, OP_R, 3'd0, 7'd0, 1'b0, 1'b1, 7'b0100000, 1'b1, 4'h0, 3'd0, 2'd0, 2'd2, 2'd2, 2'd2, 1'b0));
    // ADD
    tbl.push_back(fetch(OP_R, 3'd0, 7'd0, 1'b1));
    tbl.push_back(decode(OP_R, 3'd0, 7'd0, 3'd4));
    tbl.push_back(mk(1'b0, OP_R, 3'd0, 7'd0, 1'b0, 1'b1, 7'b0, 1'b0, 4'h0, 3'd0, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0));
    tbl.push_back(wb(OP_R, 3'd0, 7'd0));
    // SRAI
    tbl.push_back(fetch(OP_I, 3'd5, 7'h20, 1'b1));
    tbl.push_back(decode(OP_I, 3'd5, 7'h20, 3'd4));
    tbl.push_back(mk(1'b0, OP_I, 3'd5, 7'h20, 1'b0, 1'b1, 7'b0, 1'b0, 4'h7, 3'd0, 2'd2, 2'd1, 2'd0, 2'd2, 1'b0));
    tbl.push_back(wb(OP_I, 3'd5, 7'h20));
    // LW, 3 wait cycles in FETCH and in LOAD_ACCESS
    for (int i = 0; i < 3; i++) tbl.push_back(fetch(OP_L, 3'd2, 7'd0, 1'b0));
    tbl.push_back(fetch(OP_L, 3'd2, 7'd0, 1'b1));
    tbl.push_back(decode(OP_L, 3'd2, 7'd0, 3'd4));
    tbl.push_back(mk(1'b0, OP_L, 3'd2, 7'd0, 1'b0, 1'b1, 7'b0, 1'b0, 4'h0, 3'd0, 2'd2, 2'd1, 2'd0, 2'd2, 1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, OP_L, 3'd2, 7'd0, 1'b0, 1'b0, 7'b0010000, 1'b1, 4'h0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, OP_L, 3'd2, 7'd0, 1'b0, 1'b1, 7'b0010000, 1'b1, 4'h0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, OP_L, 3'd2, 7'd0, 1'b0, 1'b1, 7'b0000010, 1'b0, 4'h0, 3'd0, 2'd0, 2'd0, 2'd1, 2'd2, 1'b0));
    // LBU
    tbl.push_back(fetch(OP_L, 3'd4, 7'd0, 1'b1));
    tbl.push_back(decode(OP_L, 3'd4, 7'd0, 3'd4));
    tbl.push_back(mk(1'b0, OP_L, 3'd4, 7'd0, 1'b0, 1'b1, 7'b0, 1'b0, 4'h0, 3'd0, 2'd2, 2'd1, 2'd0, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, OP_L, 3'd4, 7'd0, 1'b0, 1'b1, 7'b0010000, 1'b1, 4'h0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1));
    tbl.push_back(mk(1'b0, OP_L, 3'd4, 7'd0, 1'b0, 1'b1, 7'b0000010, 1'b0, 4'h0, 3'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1));
    // SB
    tbl.push_back(fetch(OP_S, 3'd0, 7'd0, 1'b1));
    tbl.push_back(decode(OP_S, 3'd0, 7'd0, 3'd4));
    tbl.push_back(mk(1'b0, OP_S, 3'd0, 7'd0, 1'b0, 1'b1, 7'b0, 1'b0, 4'h0, 3'd1, 2'd2, 2'd1, 2'd0, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, OP_S, 3'd0, 7'd0, 1'b0, 1'b1, 7'b0010001, 1'b1, 4'h0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0));
    // BLTU, sltu(1, 0xFFFFFFFF)=1 so Zero=0 -> taken
    tbl.push_back(fetch(OP_B, 3'd6, 7'd0, 1'b1));
    tbl.push_back(decode(OP_B, 3'd6, 7'd0, 3'd2));
    tbl.push_back(mk(1'b0, OP_B, 3'd6, 7'd0, 1'b0, 1'b1, 7'b1000000, 1'b0, 4'h8, 3'd2, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0));
    // BGE equal operands: slt=0 so Zero=1 -> taken
    tbl.push_back(fetch(OP_B, 3'd5, 7'd0, 1'b1));
    tbl.push_back(decode(OP_B, 3'd5, 7'd0, 3'd2));
    tbl.push_back(mk(1'b0, OP_B, 3'd5, 7'd0, 1'b1, 1'b1, 7'b1000000, 1'b0, 4'hD, 3'd2, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0));
    // BEQ with Zero=0 -> not taken
    tbl.push_back(fetch(OP_B, 3'd0, 7'd0, 1'b1));
    tbl.push_back(decode(OP_B, 3'd0, 7'd0, 3'd2));
    tbl.push_back(mk(1'b0, OP_B, 3'd0, 7'd0, 1'b0, 1'b1, 7'b0, 1'b0, 4'h1, 3'd2, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0));
    // JALR
    tbl.push_back(fetch(OP_JR, 3'd0, 7'd0, 1'b1));
    tbl.push_back(decode(OP_JR, 3'd0, 7'd0, 3'd4));
    tbl.push_back(mk(1'b0, OP_JR, 3'd0, 7'd0, 1'b0, 1'b1, 7'b1000000, 1'b0, 4'h0, 3'd0, 2'd2, 2'd1, 2'd2, 2'd2, 1'b0));
    tbl.push_back(mk(1'b0, OP_JR, 3'd0, 7'd0, 1'b0, 1'b1, 7'b0, 1'b0, 4'h0, 3'd0, 2'd1, 2'd2, 2'd0, 2'd2, 1'b0));
    tbl.push_back(wb(OP_JR, 3'd0, 7'd0));
    // LUI
    tbl.push_back(fetch(OP_LUI, 3'd0, 7'd0, 1'b1));
    tbl.push_back(decode(OP_LUI, 3'd0, 7'd0, 3'd4));
    tbl.push_back(mk(1'b0, OP_LUI, 3'd0, 7'd0, 1'b0, 1'b1, 7'b0000010, 1'b0, 4'h0, 3'd3, 2'd0, 2'd0, 2'd3, 2'd2, 1'b0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; opcode = tbl[i].op; funct3 = tbl[i].f3; funct7 = tbl[i].f7;
      Zero = tbl[i].z; rdy = tbl[i].rdy;
      #1;
      a = act_out();
      e = {tbl[i].en, tbl[i].mreq, tbl[i].alu, tbl[i].imm, tbl[i].sa, tbl[i].sb,
           tbl[i].rs, tbl[i].sz, tbl[i].uns};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL row%0d: got %06h expected %06h", i, a, e);
      end
      cyc();
    end
    // 45 cycles, 10 instructions
    check("table_cycles", 32'(CycleCount), 32'd45);
    check("table_retired", 32'(InstRetired), 32'd10);

    // ADD with MemReady tied high
    do_reset();
    check("reset_cycles", 32'(CycleCount), 32'd0);
    check("reset_flags", {30'd0, Illegal, BusError}, 32'd0);
    opcode = OP_R; funct3 = 3'd0; funct7 = 7'd0; rdy = 1'b1;
    repeat (3) cyc();
    check("add_regwrite_c4", 32'(RegWrite), 32'd1);
    cyc();
    check("add_retired", 32'(InstRetired), 32'd1);
    check("add_cycles", 32'(CycleCount), 32'd4);

    // FETCH timeout: 4 wait cycles tolerated, the 5th without MemReady traps
    do_reset();
    repeat (4) cyc();
    check("to_still_fetch", {30'd0, mif.MemRequest, BusError}, 32'h2);
    cyc();
    check("to_trap_req", 32'(mif.MemRequest), 32'd0);
    check("to_buserror", 32'(BusError), 32'd1);
    check("to_cycles", 32'(CycleCount), 32'd5);
    rdy = 1'b1;
    repeat (3) cyc();
    check("to_frozen", 32'(CycleCount), 32'd5);
    check("to_trap_pce", 32'(PCEnable), 32'd0);
    check("to_retired", 32'(InstRetired), 32'd0);

    // MemReady in the cycle the limit is reached completes the fetch
    do_reset();
    repeat (4) cyc();
    rdy = 1'b1;
    #1;
    check("edge_pce", 32'(PCEnable), 32'd1);
    cyc();
    check("edge_decode", {30'd0, REGAEnable, BusError}, 32'h2);

    // FENCE retires as a 2-cycle NOP
    do_reset();
    opcode = OP_FEN; rdy = 1'b1;
    repeat (2) cyc();
    check("fence_retired", 32'(InstRetired), 32'd1);
    check("fence_fetch", 32'(mif.MemRequest), 32'd1);

    // Illegal encodings
    ill[0] = {OP_SYS, 3'd0}; ill[1] = {OP_L, 3'd3}; ill[2] = {OP_S, 3'd3}; ill[3] = {OP_B, 3'd2};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      opcode = ill[k][9:3]; funct3 = ill[k][2:0]; rdy = 1'b1;
      repeat (2) cyc();
`ifdef ILLEGAL_TRAP_EN
      check($sformatf("ill%0d_flag", k), 32'(Illegal), 32'd1);
      check($sformatf("ill%0d_retired", k), 32'(InstRetired), 32'd0);
      check($sformatf("ill%0d_req", k), 32'(mif.MemRequest), 32'd0);
`else
      check($sformatf("ill%0d_flag", k), 32'(Illegal), 32'd0);
      check($sformatf("ill%0d_retired", k), 32'(InstRetired), 32'd1);
      check($sformatf("ill%0d_req", k), 32'(mif.MemRequest), 32'd1);
`endif
    end

    // Reset during STORE_ACCESS
    do_reset();
    opcode = OP_S; funct3 = 3'd2; rdy = 1'b1;
    repeat (3) cyc();
    rdy = 1'b0;
    #1;
    check("st_mw_before", 32'(mif.MemWrite), 32'd1);
    cyc();
    reset = 1'b1;
    #1;
    check("st_mw_in_reset", 32'(mif.MemWrite), 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    check("st_after_reset", {30'd0, mif.MemWrite, mif.MemRequest}, 32'h1);
    check("st_counters", {16'd0, 8'(CycleCount), 8'(InstRetired)}, 32'd0);

    // Counter wrap at CNT_W=8: 70 ADDs = 280 cycles
    do_reset();
    opcode = OP_R; funct3 = 3'd0; rdy = 1'b1;
    repeat (280) cyc();
    check("wrap_cycles", 32'(CycleCount), 32'd24);
    check("wrap_retired", 32'(InstRetired), 32'd70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
